// File: rtl/osd_debug_scheduler.sv
// Frame-synchronous round-robin scheduler that shares the 8-bit OSD debug overlay between NUM_SRC sources.
// Optional no-capture timeout that hides the overlay: define OSD_TIMEOUT_EN.
module osd_debug_scheduler #(
  parameter int NUM_SRC        = 4,
  parameter int DWELL_FRAMES   = 60,
  parameter int TIMEOUT_FRAMES = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 VBLANK,
  input  logic                 freeze,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [8*NUM_SRC-1:0] src_value,
  output logic [NUM_SRC-1:0]   src_ack,
  output logic [7:0]           debug_value,
  output logic [3:0]           debug_src,
  output logic                 osd_show,
  output logic                 frame_tick,
  output logic                 dbg_state
);

  // Handshake: src_req is a level held while a source has data to show; src_ack pulses
  // for one clk on the vb_start edge that captures src_value of that source. There is no
  // backpressure: a source may drop src_req at any time, and at most one ack is high per clk.

  localparam int DW = $clog2(DWELL_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_FRAMES - 1);
  localparam logic [NUM_SRC-1:0] ONE_HOT0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            vblank_d;
  logic            vb_start;
  logic [3:0]      ptr_q, ptr_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [7:0]      value_d;
  logic [3:0]      src_d;
  logic            show_d;
  logic [NUM_SRC-1:0] ack_d;
  logic [NUM_SRC-1:0] owner_mask;
  logic [NUM_SRC-1:0] others;
  logic            owner_req;
  logic [4:0]      pick_all;
  logic [4:0]      pick_oth;
  logic            capture;
  logic [3:0]      grant;
  logic [7:0]      grant_value;

  // Returns {found, index} of the first requester strictly after 'from', wrapping.
  function automatic logic [4:0] rr_pick(input logic [NUM_SRC-1:0] req, input logic [3:0] from);
    logic [4:0] res;
    res = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      int idx;
      idx = (int'(from) + k) % NUM_SRC;
      if (!res[4] && req[idx]) res = {1'b1, 4'(idx)};
    end
    return res;
  endfunction

  assign vb_start   = VBLANK & ~vblank_d;
  assign owner_mask = ONE_HOT0 << debug_src;
  assign owner_req  = |(src_req & owner_mask);
  assign others     = src_req & ~owner_mask;
  assign pick_all   = rr_pick(src_req, ptr_q);
  assign pick_oth   = rr_pick(others, ptr_q);
  assign dbg_state  = (state_q == SHOW);

  always_comb begin
    grant_value = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == 4'(i)) grant_value = src_value[8*i +: 8];
    end
  end

`ifdef OSD_TIMEOUT_EN
  logic [7:0] idle_cnt_q, idle_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT_FRAMES);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    value_d = debug_value;
    src_d   = debug_src;
    show_d  = osd_show;
    ack_d   = '0;
    capture = 1'b0;
    grant   = debug_src;
`ifdef OSD_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
`endif
    if (vb_start && !freeze) begin
      if (state_q == IDLE) begin
        if (pick_all[4]) begin
          grant   = pick_all[3:0];
          capture = 1'b1;
          state_d = SHOW;
          show_d  = 1'b1;
          dwell_d = '0;
        end
      end else begin
        if (|others && (!owner_req || dwell_q >= DWELL_MAX)) begin
          grant   = pick_oth[3:0];
          capture = 1'b1;
          dwell_d = '0;
        end else begin
          // Owner keeps the slot; with its request low the last value simply stays on screen.
          capture = owner_req;
          if (dwell_q < DWELL_MAX) dwell_d = dwell_q + 1'b1;
        end
      end
      if (capture) begin
        value_d = grant_value;
        src_d   = grant;
        ptr_d   = grant;
        ack_d   = ONE_HOT0 << grant;
      end
`ifdef OSD_TIMEOUT_EN
      if (capture) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q + 8'd1 == 8'(TIMEOUT_FRAMES)) begin
        show_d     = 1'b0;
        state_d    = IDLE;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 8'd1;
      end
`endif
    end
  end

  // vblank_d resets high so a VBLANK already asserted at release is not a frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      vblank_d    <= 1'b1;
      ptr_q       <= 4'(NUM_SRC - 1);
      dwell_q     <= '0;
      debug_value <= '0;
      debug_src   <= '0;
      osd_show    <= 1'b0;
      src_ack     <= '0;
      frame_tick  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vblank_d    <= VBLANK;
      ptr_q       <= ptr_d;
      dwell_q     <= dwell_d;
      debug_value <= value_d;
      debug_src   <= src_d;
      osd_show    <= show_d;
      src_ack     <= ack_d;
      frame_tick  <= vb_start;
    end
  end

`ifdef OSD_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idle_cnt_q <= '0;
    else          idle_cnt_q <= idle_cnt_d;
  end
`endif

endmodule

// File: tb/tb_osd_debug_scheduler.sv
// Bench for osd_debug_scheduler: directed scenarios plus randomized frames against a frame-level model.
// Build with OSD_TIMEOUT_EN defined to cover the overlay timeout as well.
module tb_osd_debug_scheduler;
  localparam int N  = 4;
  localparam int DW = 3;
  localparam int TO = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           VBLANK;
  logic           freeze;
  logic [N-1:0]   src_req;
  logic [8*N-1:0] src_value;
  logic [N-1:0]   src_ack;
  logic [7:0]     debug_value;
  logic [3:0]     debug_src;
  logic           osd_show;
  logic           frame_tick;
  logic           dbg_state;

  osd_debug_scheduler #(.NUM_SRC(N), .DWELL_FRAMES(DW), .TIMEOUT_FRAMES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .VBLANK(VBLANK), .freeze(freeze),
    .src_req(src_req), .src_value(src_value), .src_ack(src_ack),
    .debug_value(debug_value), .debug_src(debug_src), .osd_show(osd_show),
    .frame_tick(frame_tick), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int tick_count = 0;
  always @(posedge clk) if (frame_tick) tick_count <= tick_count + 1;

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // frame-level reference model
  int         m_state;   // 0 = nobody owns the overlay, 1 = owner shown
  int         m_src;
  int         m_last;
  int         m_dwell;
  int         m_cnt;
  logic [7:0] m_value;
  logic       m_show;
  logic [N-1:0] m_ack;

  task automatic model_reset();
    m_state = 0; m_src = 0; m_last = N - 1; m_dwell = 0; m_cnt = 0;
    m_value = 8'h00; m_show = 1'b0; m_ack = '0;
    exp_q.delete();
  endtask

  function automatic int next_req(input logic [N-1:0] req, input int after);
    for (int k = 1; k <= N; k++) begin
      if (req[(after + k) % N]) return (after + k) % N;
    end
    return -1;
  endfunction

  task automatic model_vb_start();
    int g;
    logic [N-1:0] others;
    m_ack = '0;
    if (freeze) return;
    g = -1;
    if (m_state == 0) begin
      g = next_req(src_req, m_last);
      if (g >= 0) begin m_state = 1; m_show = 1'b1; m_dwell = 0; end
    end else begin
      others = src_req;
      others[m_src] = 1'b0;
      if (others != 0 && (!src_req[m_src] || m_dwell >= DW - 1)) begin
        g = next_req(others, m_src);
        m_dwell = 0;
      end else begin
        if (src_req[m_src]) g = m_src;
        if (m_dwell < DW - 1) m_dwell++;
      end
    end
    if (g >= 0) begin
      m_value = src_value[8*g +: 8];
      m_src = g;
      m_last = g;
      m_ack[g] = 1'b1;
      exp_q.push_back(m_value);
      m_cnt = 0;
    end else begin
`ifdef OSD_TIMEOUT_EN
      m_cnt++;
      if (m_cnt == TO) begin m_show = 1'b0; m_state = 0; m_cnt = 0; end
`endif
    end
  endtask

  task automatic check_outputs(input logic exp_tick);
    check("debug_value", debug_value, m_value);
    check("debug_src", debug_src, m_src);
    check("osd_show", osd_show, m_show);
    check("src_ack", src_ack, m_ack);
    check("frame_tick", frame_tick, exp_tick);
    check("state", dbg_state, m_state);
  endtask

  // drivers
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; VBLANK = 1'b0; freeze = 1'b0; src_req = '0;
    #1;
    model_reset();
    check_outputs(1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_frame(input bit jitter);
    logic [7:0] v;
    @(negedge clk);
    VBLANK = 1'b1;
    model_vb_start();
    @(negedge clk);
    check_outputs(1'b1);
    if (src_ack != 0) begin
      if (exp_q.size() == 0) check("sb_unexpected_ack", 1, 0);
      else begin
        v = exp_q.pop_front();
        check("sb_value", debug_value, v);
      end
    end
    @(negedge clk);
    check("ack_pulse", src_ack, 0);
    check("tick_pulse", frame_tick, 0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    VBLANK = 1'b0;
    repeat ($urandom_range(2, 4)) begin
      @(negedge clk);
      if (jitter) src_value = $urandom;
      check("value_hold", debug_value, m_value);
      check("src_hold", debug_src, m_src);
    end
  endtask

  int t2_exp[7] = '{0, 0, 0, 2, 2, 2, 0};
  int ticks0;

  initial begin
    reset_n = 1'b0; VBLANK = 1'b0; freeze = 1'b0; src_req = '0; src_value = '0;
    model_reset();
    #2;
    check_outputs(1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // first grant goes to source 0
    do_reset();
    src_req = 4'b0001; src_value = 32'h000000A5;
    do_frame(1'b0);
    check("t1_value", debug_value, 8'hA5);

    // dwell-limited round-robin between sources 0 and 2
    do_reset();
    src_req = 4'b0101; src_value = 32'h00330011;
    for (int f = 0; f < 7; f++) begin
      do_frame(1'b0);
      check("t2_src", debug_src, t2_exp[f]);
    end

    // owner drops its request while another source waits
    do_reset();
    src_req = 4'b0010; src_value = 32'h44332211;
    do_frame(1'b0);
    src_req = 4'b1000;
    do_frame(1'b0);
    check("t3_ack_src", debug_src, 3);

    // value change mid-frame is only picked up at the next frame start
    do_reset();
    src_req = 4'b0001; src_value = 32'h00000010;
    do_frame(1'b0);
    src_value = 32'h00000020;
    do_frame(1'b0);
    check("t4_value", debug_value, 8'h20);

    // freeze holds everything while frame_tick keeps pulsing
    src_req = 4'b1111; freeze = 1'b1; src_value = 32'hDEADBEEF;
    ticks0 = tick_count;
    repeat (5) do_frame(1'b1);
    check("t5_ticks", tick_count - ticks0, 5);
    check("t5_value", debug_value, 8'h20);
    freeze = 1'b0;

    // request-free frames, then a new request
    do_reset();
    src_req = 4'b0001; src_value = 32'h000000C3;
    do_frame(1'b0);
    src_req = 4'b0000;
    repeat (TO) do_frame(1'b1);
`ifdef OSD_TIMEOUT_EN
    check("t6_hidden", osd_show, 0);
`else
    check("t6_shown", osd_show, 1);
`endif
    src_req = 4'b0010; src_value = 32'h00005A00;
    do_frame(1'b0);
    check("t6_regrant_show", osd_show, 1);
    check("t6_regrant_src", debug_src, 1);

    // asynchronous reset mid-frame with VBLANK held high through release
    @(negedge clk);
    VBLANK = 1'b1; src_req = 4'b1111;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs(1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rel_no_ack", src_ack, 0);
      check("rel_no_tick", frame_tick, 0);
    end
    VBLANK = 1'b0;
    repeat (2) @(negedge clk);
    do_frame(1'b0);
    check("rel_first_src", debug_src, 0);

    // randomized frames
    for (int f = 0; f < 200; f++) begin
      if ($urandom_range(0, 3) == 0) src_req = N'($urandom_range(0, 15));
      freeze = ($urandom_range(0, 7) == 0);
      src_value = $urandom;
      do_frame(1'b1);
    end
    freeze = 1'b0;

    check("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
